// File: rtl/vov_voter.sv
// Per-bit majority voter over windows of WIN vote vectors, fed through a small
// input FIFO; a flush pulse closes a partial window early.
module vov_voter #(
  parameter int K     = 4,
  parameter int WIN   = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] vov,
  input  logic         vov_valid,
  input  logic         flush,
  output logic [K-1:0] out_vec,
  output logic [3:0]   out_count,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [3:0]    WIN4 = 4'(WIN);
  localparam logic [4:0]    WIN5 = 5'(WIN);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

  logic [K-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q [K];
  logic [3:0]    cnt_d [K];
  logic [3:0]    vcnt_q, vcnt_d;
  logic [K-1:0]  out_vec_q, out_vec_d;
  logic [3:0]    out_count_q, out_count_d;
  logic          out_valid_q, out_valid_d;

  logic          fifo_full, fifo_empty, push, pop;
  logic [K-1:0]  pop_data;

  // A full FIFO refuses a push even when a pop frees a slot on the same edge.
  assign fifo_full  = (count_q == FULL);
  assign fifo_empty = (count_q == '0);
  assign push       = vov_valid && !fifo_full;
  assign pop        = (state_q == ACCUM) && !fifo_empty;
  assign pop_data   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (vov_valid & fifo_full);
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    vcnt_d      = vcnt_q;
    out_vec_d   = out_vec_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        for (int i = 0; i < K; i++) cnt_d[i] = '0;
        vcnt_d  = '0;
        state_d = ACCUM;
      end
      ACCUM: begin
        if (pop) begin
          for (int i = 0; i < K; i++) cnt_d[i] = cnt_q[i] + {3'b000, pop_data[i]};
          vcnt_d = vcnt_q + 4'd1;
        end
        // A full window wins over a coincident flush.
        if (pop && vcnt_d == WIN4) begin
          for (int i = 0; i < K; i++) out_vec_d[i] = ({cnt_d[i], 1'b0} > WIN5);
          out_count_d = WIN4;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end else if (flush && vcnt_d != 4'd0) begin
          for (int i = 0; i < K; i++) out_vec_d[i] = ({cnt_d[i], 1'b0} > {1'b0, vcnt_d});
          out_count_d = vcnt_d;
          out_valid_d = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          for (int i = 0; i < K; i++) cnt_d[i] = '0;
          vcnt_d      = '0;
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= vov;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= IDLE;
      for (int i = 0; i < K; i++) cnt_q[i] <= '0;
      vcnt_q      <= '0;
      out_vec_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vcnt_q      <= vcnt_d;
      out_vec_q   <= out_vec_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_vec   = out_vec_q;
  assign out_count = out_count_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_vov_voter.sv
// Scenario bench for vov_voter: directed windows plus randomized windows
// checked against a per-bit vote count over the accepted vectors.
module tb_vov_voter;

  localparam int K     = 4;
  localparam int WIN   = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [K-1:0] vov;
  logic         vov_valid;
  logic         flush;
  logic [K-1:0] out_vec;
  logic [3:0]   out_count;
  logic         out_valid;
  logic         out_ready;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  logic [K-1:0] window_q[$];

  always #5 clk = ~clk;

  vov_voter #(.K(K), .WIN(WIN), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .vov       (vov),
    .vov_valid (vov_valid),
    .flush     (flush),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bit i is set when strictly more than half of the window has bit i set.
  function automatic logic [K-1:0] model_vote();
    logic [K-1:0] r;
    r = '0;
    for (int i = 0; i < K; i++) begin
      int ones;
      ones = 0;
      foreach (window_q[j]) ones += int'(window_q[j][i]);
      r[i] = (2 * ones > window_q.size());
    end
    return r;
  endfunction

  task automatic push_same(input logic [K-1:0] v, input int n);
    for (int j = 0; j < n; j++) window_q.push_back(v);
    vov = v;
    vov_valid = 1'b1;
    repeat (n) tick();
    vov_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vov = '0; vov_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_vec !== '0) begin errors++; $display("[TB] FAIL reset_vec got %0h exp 0", out_vec); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", out_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow got %0b exp 0", overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_window();
    logic [K-1:0] exp_vec;
    window_q.delete();
    push_same(4'b1011, WIN);
    exp_vec = model_vote();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_early_valid got %0b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_latency got %0b exp 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL full_vec got %0h exp %0h", out_vec, exp_vec); end
    checks++; if (out_count !== 4'(WIN)) begin errors++; $display("[TB] FAIL full_count got %0d exp %0d", out_count, WIN); end
    repeat (3) tick();
    checks++; if (out_valid !== 1'b1 || out_vec !== exp_vec) begin errors++; $display("[TB] FAIL full_hold got %0b/%0h exp 1/%0h", out_valid, out_vec, exp_vec); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_release got %0b exp 0", out_valid); end
  endtask

  task automatic test_tie_and_majority();
    logic [K-1:0] exp_vec;
    for (int s = 0; s < 2; s++) begin
      int t;
      window_q.delete();
      if (s == 0) begin push_same(4'b1111, 4); push_same(4'b0000, 4); end
      else        begin push_same(4'b0001, 5); push_same(4'b1000, 3); end
      exp_vec = model_vote();
      t = 0;
      while (!out_valid && t < 40) begin tick(); t++; end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL vote%0d_timeout got %0b exp 1", s, out_valid); end
      checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL vote%0d_vec got %0h exp %0h", s, out_vec, exp_vec); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [K-1:0] exp_vec;
    logic [K-1:0] v;
    int t;
    window_q.delete();
    push_same(4'b0101, WIN);
    exp_vec = model_vote();
    tick();
    checks++; if (out_valid !== 1'b1 || out_vec !== exp_vec) begin errors++; $display("[TB] FAIL bp_first got %0b/%0h exp 1/%0h", out_valid, out_vec, exp_vec); end
    window_q.delete();
    vov_valid = 1'b1;
    for (int j = 0; j < DEPTH + 1; j++) begin
      v = K'($urandom);
      if (j < DEPTH) window_q.push_back(v);
      vov = v;
      tick();
    end
    vov_valid = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL bp_overflow got %0b exp 1", overflow); end
    checks++; if (out_vec !== exp_vec || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold got %0b/%0h exp 1/%0h", out_valid, out_vec, exp_vec); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick();
    vov_valid = 1'b1;
    for (int j = 0; j < WIN - DEPTH; j++) begin
      v = K'($urandom);
      window_q.push_back(v);
      vov = v;
      tick();
    end
    vov_valid = 1'b0;
    exp_vec = model_vote();
    t = 0;
    while (!out_valid && t < 40) begin tick(); t++; end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_second_timeout got %0b exp 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL bp_second_vec got %0h exp %0h", out_vec, exp_vec); end
    checks++; if (out_count !== 4'(WIN)) begin errors++; $display("[TB] FAIL bp_second_count got %0d exp %0d", out_count, WIN); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL bp_sticky got %0b exp 1", overflow); end
  endtask

  task automatic test_flush();
    logic [K-1:0] exp_vec;
    window_q.delete();
    push_same(4'b0110, 3);
    exp_vec = model_vote();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_valid got %0b exp 1", out_valid); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL flush_vec got %0h exp %0h", out_vec, exp_vec); end
    checks++; if (out_count !== 4'd3) begin errors++; $display("[TB] FAIL flush_count got %0d exp 3", out_count); end
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_count !== 4'd3 || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_emit got %0b/%0d exp 1/3", out_valid, out_count); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_empty got %0b exp 0", out_valid); end
    window_q.delete();
    push_same(4'b1110, WIN);
    exp_vec = model_vote();
    flush = 1'b1; tick(); flush = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_count !== 4'(WIN)) begin errors++; $display("[TB] FAIL flush_collide got %0b/%0d exp 1/%0d", out_valid, out_count, WIN); end
    checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL flush_collide_vec got %0h exp %0h", out_vec, exp_vec); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [K-1:0] exp_vec;
    int t;
    window_q.delete();
    push_same(4'b0111, WIN);
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_emit_valid got %0b exp 0", out_valid); end
    window_q.delete();
    push_same(4'b0011, 5);
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out_vec !== '0 || out_count !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_outputs got %0h/%0d/%0b exp 0/0/0", out_vec, out_count, out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_overflow got %0b exp 0", overflow); end
    repeat (10) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_partial got %0b exp 0", out_valid); end
    window_q.delete();
    push_same(4'b1100, WIN);
    exp_vec = model_vote();
    t = 0;
    while (!out_valid && t < 40) begin tick(); t++; end
    checks++; if (out_vec !== exp_vec || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_after_vec got %0b/%0h exp 1/%0h", out_valid, out_vec, exp_vec); end
    checks++; if (out_count !== 4'(WIN)) begin errors++; $display("[TB] FAIL rst_after_count got %0d exp %0d", out_count, WIN); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [K-1:0] exp_vec;
    logic [K-1:0] v;
    for (int w = 0; w < 20; w++) begin
      bit use_flush;
      int n;
      int t;
      window_q.delete();
      use_flush = ($urandom_range(0, 2) == 0);
      n = use_flush ? $urandom_range(1, WIN - 1) : WIN;
      for (int j = 0; j < n; j++) begin
        v = K'($urandom);
        window_q.push_back(v);
        vov = v;
        vov_valid = 1'b1;
        tick();
        vov_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      if (use_flush) begin
        repeat (3) tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_early got %0b exp 0", w, out_valid); end
        flush = 1'b1; tick(); flush = 1'b0;
      end
      exp_vec = model_vote();
      t = 0;
      while (!out_valid && t < 40) begin tick(); t++; end
      repeat ($urandom_range(0, 3)) tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_valid got %0b exp 1", w, out_valid); end
      checks++; if (out_vec !== exp_vec) begin errors++; $display("[TB] FAIL rand%0d_vec got %0h exp %0h", w, out_vec, exp_vec); end
      checks++; if (out_count !== 4'(n)) begin errors++; $display("[TB] FAIL rand%0d_count got %0d exp %0d", w, out_count, n); end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL rand_overflow got %0b exp 0", overflow); end
  endtask

  initial begin
    test_reset();
    test_full_window();
    test_tie_and_majority();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
